// File: rtl/conv_stream_engine.sv
// Streaming 2-D convolution: raster-order pixels in, padded KxK window from line buffers,
// requantised/ReLU/saturated pixels out. Optional signed bias input under `CONV_BIAS_EN`.
module conv_stream_engine #(
   parameter int IFMAP_HEIGHT  = 32,
   parameter int IFMAP_WIDTH   = 32,
   parameter int KERNEL_HEIGHT = 3,
   parameter int KERNEL_WIDTH  = 3,
   parameter int DATA_WIDTH    = 8,
   parameter int CHANNELS      = 1,
   parameter int H_STRIDE      = 1,
   parameter int V_STRIDE      = 1,
   parameter int PADDING       = 1
) (
   input  logic                                                   clk,
   input  logic                                                   reset,
   input  logic                                                   start,
   input  logic [CHANNELS*KERNEL_HEIGHT*KERNEL_WIDTH*DATA_WIDTH-1:0] weights,
   input  logic [4:0]                                             shift,
`ifdef CONV_BIAS_EN
   input  logic signed [2*DATA_WIDTH-1:0]                         bias,
`endif
   input  logic                                                   in_valid,
   output logic                                                   in_ready,
   input  logic [CHANNELS*DATA_WIDTH-1:0]                         in_data,
   output logic                                                   out_valid,
   input  logic                                                   out_ready,
   output logic [DATA_WIDTH-1:0]                                  out_data,
   output logic                                                   out_last,
   output logic                                                   busy,
   output logic                                                   done
);
   // Handshakes: a transfer happens on a rising clk edge where valid && ready; the producer
   // holds valid and data stable until that edge.
   localparam int PH     = IFMAP_HEIGHT + 2*PADDING;
   localparam int PW     = IFMAP_WIDTH + 2*PADDING;
   localparam int OH     = (PH - KERNEL_HEIGHT) / V_STRIDE + 1;
   localparam int OW     = (PW - KERNEL_WIDTH) / H_STRIDE + 1;
   localparam int PIX_W  = CHANNELS*DATA_WIDTH;
   localparam int ACC_W  = 2*DATA_WIDTH + 1 + $clog2(CHANNELS*KERNEL_HEIGHT*KERNEL_WIDTH);
   localparam int RW     = (PH > 1) ? $clog2(PH) : 1;
   localparam int CW     = (PW > 1) ? $clog2(PW) : 1;
   localparam int LB_N   = (KERNEL_HEIGHT > 1) ? KERNEL_HEIGHT-1 : 1;
   localparam int LAST_R = (OH-1)*V_STRIDE + KERNEL_HEIGHT - 1;
   localparam int LAST_C = (OW-1)*H_STRIDE + KERNEL_WIDTH - 1;
   localparam logic signed [ACC_W-1:0] MAX_Q = ACC_W'((1 << DATA_WIDTH) - 1);

   typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DONE} state_t;

   state_t state_q, state_d;
   logic [RW-1:0] pr;
   logic [CW-1:0] pc;
   logic          scan_end;
   logic [CHANNELS*KERNEL_HEIGHT*KERNEL_WIDTH*DATA_WIDTH-1:0] w_q;
   logic [4:0]    shift_q;
`ifdef CONV_BIAS_EN
   logic signed [2*DATA_WIDTH-1:0] bias_q;
`endif

   logic [PIX_W-1:0] lb    [LB_N][PW];
   logic [PIX_W-1:0] win   [KERNEL_HEIGHT][KERNEL_WIDTH];
   logic [PIX_W-1:0] win_n [KERNEL_HEIGHT][KERNEL_WIDTH];
   logic [PIX_W-1:0] col   [KERNEL_HEIGHT];
   logic [PIX_W-1:0] px_in;

   logic border, stall, scan_on, advance, emit, last_win;
   int   pr_i, pc_i;
   logic signed [ACC_W-1:0] acc, q, px_s, wt_s;
   logic [DATA_WIDTH-1:0]   sat;

   always_comb begin
      pr_i     = int'(pr);
      pc_i     = int'(pc);
      border   = (pr_i < PADDING) || (pr_i >= PADDING + IFMAP_HEIGHT) ||
                 (pc_i < PADDING) || (pc_i >= PADDING + IFMAP_WIDTH);
      stall    = out_valid && !out_ready;
      scan_on  = (state_q == S_STREAM) && !scan_end && !stall;
      in_ready = scan_on && !border;
      advance  = scan_on && (border || in_valid);
      px_in    = border ? '0 : in_data;
      emit     = (pr_i >= KERNEL_HEIGHT-1) && (pc_i >= KERNEL_WIDTH-1) &&
                 (((pr_i - KERNEL_HEIGHT + 1) % V_STRIDE) == 0) &&
                 (((pc_i - KERNEL_WIDTH + 1) % H_STRIDE) == 0);
      last_win = (pr_i == LAST_R) && (pc_i == LAST_C);
   end

   // Column entering the window: oldest buffered row at k=0, the live pixel at the bottom.
   always_comb begin
      col[KERNEL_HEIGHT-1] = px_in;
      for (int k = 0; k < KERNEL_HEIGHT-1; k++) col[k] = lb[KERNEL_HEIGHT-2-k][pc];
      for (int k = 0; k < KERNEL_HEIGHT; k++) begin
         for (int c = 0; c < KERNEL_WIDTH-1; c++) win_n[k][c] = win[k][c+1];
         win_n[k][KERNEL_WIDTH-1] = col[k];
      end
   end

   // MAC over the window as it will look after this advance, so the result registers with it.
   always_comb begin
`ifdef CONV_BIAS_EN
      acc = ACC_W'(bias_q);
`else
      acc = '0;
`endif
      px_s = '0;
      wt_s = '0;
      for (int ch = 0; ch < CHANNELS; ch++)
         for (int k = 0; k < KERNEL_HEIGHT; k++)
            for (int c = 0; c < KERNEL_WIDTH; c++) begin
               px_s = ACC_W'($signed({1'b0, win_n[k][c][ch*DATA_WIDTH +: DATA_WIDTH]}));
               wt_s = ACC_W'($signed(w_q[((ch*KERNEL_HEIGHT+k)*KERNEL_WIDTH+c)*DATA_WIDTH +: DATA_WIDTH]));
               acc  = acc + px_s * wt_s;
            end
      q = acc >>> shift_q;
      if (q[ACC_W-1])   sat = '0;
      else if (q > MAX_Q) sat = '1;
      else              sat = q[DATA_WIDTH-1:0];
   end

   always_comb begin
      state_d = state_q;
      busy    = 1'b0;
      done    = 1'b0;
      case (state_q)
         S_IDLE:   if (start) state_d = S_STREAM;
         S_STREAM: begin
            busy = 1'b1;
            if (out_valid && out_ready && out_last) state_d = S_DONE;
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default:  state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         pr        <= '0;
         pc        <= '0;
         scan_end  <= 1'b0;
         w_q       <= '0;
         shift_q   <= '0;
`ifdef CONV_BIAS_EN
         bias_q    <= '0;
`endif
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == S_IDLE && start) begin
            w_q      <= weights;
            shift_q  <= shift;
`ifdef CONV_BIAS_EN
            bias_q   <= bias;
`endif
            pr       <= '0;
            pc       <= '0;
            scan_end <= 1'b0;
         end
         if (advance) begin
            if (pc == CW'(PW-1)) begin
               pc <= '0;
               pr <= pr + RW'(1);
            end else begin
               pc <= pc + CW'(1);
            end
            if (emit && last_win) scan_end <= 1'b1;
         end
         if (advance && emit) begin
            out_valid <= 1'b1;
            out_data  <= sat;
            out_last  <= last_win;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
         end
      end
   end

   // Storage only; contents are don't-care until overwritten by the current frame.
   always_ff @(posedge clk) begin
      if (advance) begin
         for (int k = 0; k < KERNEL_HEIGHT; k++)
            for (int c = 0; c < KERNEL_WIDTH; c++) win[k][c] <= win_n[k][c];
         if (KERNEL_HEIGHT > 1) begin
            lb[0][pc] <= px_in;
            for (int j = 1; j < LB_N; j++) lb[j][pc] <= lb[j-1][pc];
         end
      end
   end

endmodule

// File: tb/tb_conv_stream_engine.sv
// Directed bench for conv_stream_engine: 4x4 ifmap, 3x3 kernel, padding 1; a second
// instance runs stride 2. Expected pixel streams are hand-computed.
module tb_conv_stream_engine;
   localparam int DW = 8;
   localparam int WB = 9*DW;

   logic          clk = 1'b0;
   logic          reset;
   logic          start, in_valid, out_ready, sel;
   logic [DW-1:0] in_data;
   logic [WB-1:0] weights;
   logic [4:0]    shift;

   logic a_in_ready, a_out_valid, a_out_last, a_busy, a_done;
   logic b_in_ready, b_out_valid, b_out_last, b_busy, b_done;
   logic [DW-1:0] a_out_data, b_out_data;
   logic o_in_ready, o_out_valid, o_out_last, o_busy, o_done;
   logic [DW-1:0] o_out_data;

   logic [DW-1:0] exp_q [$];
   logic [DW-1:0] got_q [$];
   logic [DW-1:0] pix [16];
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   conv_stream_engine #(.IFMAP_HEIGHT(4), .IFMAP_WIDTH(4), .KERNEL_HEIGHT(3), .KERNEL_WIDTH(3),
      .DATA_WIDTH(DW), .CHANNELS(1), .H_STRIDE(1), .V_STRIDE(1), .PADDING(1)) dut_a (
      .clk(clk), .reset(reset), .start(start && !sel), .weights(weights), .shift(shift),
      .in_valid(in_valid && !sel), .in_ready(a_in_ready), .in_data(in_data),
      .out_valid(a_out_valid), .out_ready(out_ready && !sel), .out_data(a_out_data),
      .out_last(a_out_last), .busy(a_busy), .done(a_done));

   conv_stream_engine #(.IFMAP_HEIGHT(4), .IFMAP_WIDTH(4), .KERNEL_HEIGHT(3), .KERNEL_WIDTH(3),
      .DATA_WIDTH(DW), .CHANNELS(1), .H_STRIDE(2), .V_STRIDE(2), .PADDING(1)) dut_b (
      .clk(clk), .reset(reset), .start(start && sel), .weights(weights), .shift(shift),
      .in_valid(in_valid && sel), .in_ready(b_in_ready), .in_data(in_data),
      .out_valid(b_out_valid), .out_ready(out_ready && sel), .out_data(b_out_data),
      .out_last(b_out_last), .busy(b_busy), .done(b_done));

   assign o_in_ready  = sel ? b_in_ready  : a_in_ready;
   assign o_out_valid = sel ? b_out_valid : a_out_valid;
   assign o_out_data  = sel ? b_out_data  : a_out_data;
   assign o_out_last  = sel ? b_out_last  : a_out_last;
   assign o_busy      = sel ? b_busy      : a_busy;
   assign o_done      = sel ? b_done      : a_done;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic set_weights(input logic [DW-1:0] b);
      for (int i = 0; i < 9; i++) weights[i*DW +: DW] = b;
   endtask

   task automatic set_pix_ramp();
      for (int i = 0; i < 16; i++) pix[i] = DW'(i+1);
   endtask

   task automatic set_pix_const(input logic [DW-1:0] v);
      for (int i = 0; i < 16; i++) pix[i] = v;
   endtask

   task automatic check_reset_outs(input string tag);
      chk(tag, 32'({o_in_ready, o_out_valid, o_out_last, o_busy, o_done, o_out_data}), 32'd0);
   endtask

   // Runs one frame; bp_mode 1 throttles out_ready and randomises in_valid.
   // abort_n > 0 asserts reset once that many outputs have been collected.
   task automatic run_frame(input int bp_mode, input int abort_n);
      int idx = 0, done_cnt = 0, extra = 0, last_pos = 0, last_cnt = 0;
      logic fire_in, fire_out, hold_pending = 1'b0, timed_out = 1'b1, aborted = 1'b0;
      logic [DW-1:0] hold_data = '0;
      got_q.delete();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start   = 1'b0;
      weights = '1;
      shift   = 5'd31;
      for (int cyc = 0; cyc < 1500; cyc++) begin
         out_ready = (bp_mode == 0) ? 1'b1 : (cyc % 3 == 0);
         in_valid  = (bp_mode == 0) ? 1'b1 : ($urandom_range(0, 1) == 1);
         in_data   = (idx < 16) ? pix[idx] : '0;
         #1;
         if (hold_pending) chk("hold_stable", 32'({o_out_valid, o_out_data}), 32'({1'b1, hold_data}));
         fire_in      = in_valid && o_in_ready;
         fire_out     = o_out_valid && out_ready;
         hold_pending = o_out_valid && !out_ready;
         hold_data    = o_out_data;
         if (o_done) done_cnt++;
         if (fire_out) begin
            got_q.push_back(o_out_data);
            if (o_out_last) begin
               last_pos = got_q.size();
               last_cnt++;
            end
         end
         if (abort_n > 0 && got_q.size() == abort_n) begin
            aborted   = 1'b1;
            timed_out = 1'b0;
            break;
         end
         if (done_cnt > 0) begin
            extra++;
            if (extra == 4) begin
               timed_out = 1'b0;
               break;
            end
         end
         @(posedge clk);
         if (fire_in) idx++;
         @(negedge clk);
      end
      chk("frame_timeout", 32'(timed_out), 32'd0);
      for (int i = 0; i < got_q.size(); i++)
         if (i < exp_q.size()) chk($sformatf("pix%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
      if (aborted) begin
         reset = 1'b1;
         #1;
         check_reset_outs("reset_async_outs");
         @(posedge clk);
         #1;
         check_reset_outs("reset_hold_outs");
         @(negedge clk);
         reset = 1'b0;
      end else begin
         chk("out_count", got_q.size(), exp_q.size());
         chk("last_pos", last_pos, exp_q.size());
         chk("last_count", last_cnt, 1);
         chk("done_pulses", done_cnt, 1);
         chk("inputs_used", idx, 16);
         chk("idle_after", 32'({o_busy, o_done, o_in_ready}), 32'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0; sel = 1'b0;
      in_data = '0; weights = '0; shift = '0;
      repeat (3) @(negedge clk);
      #1;
      check_reset_outs("reset_state");
      @(negedge clk);
      reset = 1'b0;
      #1;
      check_reset_outs("idle_state");

      // identity kernel
      weights = '0; weights[4*DW +: DW] = 8'd1; shift = 5'd0; set_pix_ramp();
      exp_q = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 16};
      run_frame(0, 0);

      // all-ones kernel on flat 10s
      set_weights(8'd1); shift = 5'd0; set_pix_const(8'd10);
      exp_q = '{40, 60, 60, 40, 60, 90, 90, 60, 60, 90, 90, 60, 40, 60, 60, 40};
      run_frame(0, 0);

      // stride 2
      sel = 1'b1;
      set_weights(8'd1); shift = 5'd0; set_pix_const(8'd10);
      exp_q = '{40, 60, 60, 90};
      run_frame(0, 0);
      sel = 1'b0;

      // saturation high
      set_weights(8'd127); shift = 5'd0; set_pix_const(8'd255);
      exp_q.delete();
      repeat (16) exp_q.push_back(8'd255);
      run_frame(0, 0);

      // ReLU on negative weights
      set_weights(8'hFF); shift = 5'd0; set_pix_const(8'd10);
      exp_q.delete();
      repeat (16) exp_q.push_back(8'd0);
      run_frame(0, 0);

      // shift 3: 40>>3=5, 60>>3=7, 90>>3=11
      set_weights(8'd1); shift = 5'd3; set_pix_const(8'd10);
      exp_q = '{5, 7, 7, 5, 7, 11, 11, 7, 7, 11, 11, 7, 5, 7, 7, 5};
      run_frame(0, 0);

      // backpressure and bursty input
      set_weights(8'd1); shift = 5'd0; set_pix_const(8'd10);
      exp_q = '{40, 60, 60, 40, 60, 90, 90, 60, 60, 90, 90, 60, 40, 60, 60, 40};
      run_frame(1, 0);

      // abort after 5 outputs, then a clean frame
      weights = '0; weights[4*DW +: DW] = 8'd1; shift = 5'd0; set_pix_ramp();
      exp_q = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 16};
      run_frame(0, 5);
      weights = '0; weights[4*DW +: DW] = 8'd1; shift = 5'd0;
      run_frame(0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
